// File: rtl/controlador_ataque.sv
// controlador_ataque: battleship attack controller (shot map, hit/miss LED, win detection).
// Optional shot limit with loss: define LIMITE_JOGADAS_EN.
module controlador_ataque #(
    parameter int TEMPO_RESULTADO = 381,
    parameter int MAX_JOGADAS     = 15
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ligado,
    input  logic       modo,
    input  logic       confirmar_ataque,
    input  logic [2:0] ataque_colunas,
    input  logic [2:0] ataque_linhas,
    input  logic [6:0] coluna1_posicionamento,
    input  logic [6:0] coluna2_posicionamento,
    input  logic [6:0] coluna3_posicionamento,
    input  logic [6:0] coluna4_posicionamento,
    input  logic [6:0] coluna5_posicionamento,
    output logic [6:0] coluna1_saida,
    output logic [6:0] coluna2_saida,
    output logic [6:0] coluna3_saida,
    output logic [6:0] coluna4_saida,
    output logic [6:0] coluna5_saida,
    output logic [1:0] ledRGB,
    output logic       fim_de_jogo,
    output logic [3:0] jogadas
);
    typedef enum logic [1:0] {OCIOSO, VERIFICA, RESULTADO, FIM} estado_t;

    localparam logic [15:0] ULTIMO_CICLO = 16'(TEMPO_RESULTADO - 1);

    estado_t         estado_q, estado_d;
    logic [2:0]      col_q, col_d, lin_q, lin_d;
    logic [4:0][6:0] tiro_q, tiro_d, acerto_q, acerto_d;
    logic [1:0]      led_q, led_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [4:0][6:0] navio;
    logic            valido, vitoria;

    assign navio   = {coluna5_posicionamento, coluna4_posicionamento, coluna3_posicionamento,
                      coluna2_posicionamento, coluna1_posicionamento};
    assign valido  = (col_q <= 3'd4) && (lin_q <= 3'd6);
    assign vitoria = (|navio) && ((navio & ~acerto_q) == '0);

    assign coluna1_saida = tiro_q[0];
    assign coluna2_saida = tiro_q[1];
    assign coluna3_saida = tiro_q[2];
    assign coluna4_saida = tiro_q[3];
    assign coluna5_saida = tiro_q[4];
    assign ledRGB        = led_q;
    assign fim_de_jogo   = (estado_q == FIM);

`ifdef LIMITE_JOGADAS_EN
    logic [3:0] jog_q, jog_d;
    logic       limite;
    assign limite  = (jog_q == 4'(MAX_JOGADAS));
    assign jogadas = jog_q;
`else
    // Without the shot limit the counter does not exist; MAX_JOGADAS has no effect here.
    localparam logic [3:0] SEM_CONTAGEM = 4'(MAX_JOGADAS) & 4'd0;
    assign jogadas = SEM_CONTAGEM;
`endif

    // Next state: power-off clears everything, modo=0 parks in OCIOSO, otherwise run the attack sequence
    always_comb begin
        estado_d = estado_q;
        col_d    = col_q;
        lin_d    = lin_q;
        tiro_d   = tiro_q;
        acerto_d = acerto_q;
        led_d    = led_q;
        cnt_d    = cnt_q;
`ifdef LIMITE_JOGADAS_EN
        jog_d    = jog_q;
`endif
        if (!ligado) begin
            estado_d = OCIOSO;
            col_d    = '0;
            lin_d    = '0;
            tiro_d   = '0;
            acerto_d = '0;
            led_d    = 2'b00;
            cnt_d    = '0;
`ifdef LIMITE_JOGADAS_EN
            jog_d    = '0;
`endif
        end else if (!modo && estado_q != FIM) begin
            estado_d = OCIOSO;
            cnt_d    = '0;
        end else begin
            unique case (estado_q)
                OCIOSO: begin
                    if (confirmar_ataque) begin
                        col_d    = ataque_colunas;
                        lin_d    = ataque_linhas;
                        estado_d = VERIFICA;
                    end
                end
                VERIFICA: begin
                    estado_d = RESULTADO;
                    cnt_d    = '0;
                    if (!valido || tiro_q[col_q][lin_q]) begin
                        led_d = 2'b11;
                    end else begin
                        tiro_d[col_q][lin_q]   = 1'b1;
                        acerto_d[col_q][lin_q] = navio[col_q][lin_q];
                        led_d = navio[col_q][lin_q] ? 2'b10 : 2'b01;
`ifdef LIMITE_JOGADAS_EN
                        jog_d = jog_q + 4'd1;
`endif
                    end
                end
                RESULTADO: begin
                    if (cnt_q == ULTIMO_CICLO) begin
                        cnt_d    = '0;
                        estado_d = OCIOSO;
                        led_d    = 2'b00;
                        if (vitoria) begin
                            estado_d = FIM;
                            led_d    = 2'b10;
                        end
`ifdef LIMITE_JOGADAS_EN
                        else if (limite) begin
                            estado_d = FIM;
                            led_d    = 2'b01;
                        end
`endif
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= OCIOSO;
            col_q    <= '0;
            lin_q    <= '0;
            tiro_q   <= '0;
            acerto_q <= '0;
            led_q    <= 2'b00;
            cnt_q    <= '0;
`ifdef LIMITE_JOGADAS_EN
            jog_q    <= '0;
`endif
        end else begin
            estado_q <= estado_d;
            col_q    <= col_d;
            lin_q    <= lin_d;
            tiro_q   <= tiro_d;
            acerto_q <= acerto_d;
            led_q    <= led_d;
            cnt_q    <= cnt_d;
`ifdef LIMITE_JOGADAS_EN
            jog_q    <= jog_d;
`endif
        end
    end
endmodule
